// File: rtl/audio_pcm_feeder_if.sv
// ---------------------------------------------------------------------------
// audio_pcm_feeder_if
//   Stereo PCM producer handshake into audio_pcm_feeder.
//   A transfer happens on a rising clock edge with in_valid && in_ready.
//
//   Signals
//     in_valid  producer -> feeder  sample pair valid
//     in_ready  feeder -> producer  FIFO has room (not full)
//     in_left   producer -> feeder  left sample, AUDIO_BITS wide
//     in_right  producer -> feeder  right sample, captured with in_left
//
//   Modports
//     master    producer side
//     slave     feeder side
// ---------------------------------------------------------------------------
interface audio_pcm_feeder_if #(
  parameter int unsigned AUDIO_BITS = 12
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic [AUDIO_BITS-1:0] in_left;
  logic [AUDIO_BITS-1:0] in_right;

  modport master (
    output in_valid,
    output in_left,
    output in_right,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_left,
    input  in_right,
    output in_ready
  );

endinterface

// File: rtl/audio_pcm_feeder.sv
// ---------------------------------------------------------------------------
// audio_pcm_feeder
//   Stereo PCM sample buffer and output-rate pacing stage feeding a stereo DSM.
//   Producer pushes {left,right} pairs into a FIFO through pcm_in. A fractional
//   phase accumulator (modulus CLK_HZ, increment SAMPLE_HZ) produces one tick per
//   output sample period with no long-run drift. Each tick in PLAY pops one pair
//   onto the registered left_pcm/right_pcm outputs.
//
//   FSM
//     StPrime  ticks run but never pop; leaves when fill_level >= PRIME_LEVEL
//     StPlay   each tick pops; a tick with an empty FIFO flags underrun and
//              returns to StPrime, holding the last sample on the outputs
//
//   Ports
//     clk            system clock, rising edge
//     aclr_          asynchronous active-low reset
//     pcm_in         slave side of audio_pcm_feeder_if (valid/ready/left/right)
//     left_pcm       registered left sample to DSM
//     right_pcm      registered right sample to DSM
//     sample_strobe  1-cycle pulse in the cycle a new sample first appears
//     underrun       1-cycle pulse after a PLAY tick found the FIFO empty
//     playing        high while in StPlay
//     fill_level     FIFO occupancy, 0..2**FIFO_AW
//     underrun_count saturating underrun counter (only with the macro below)
//
//   Configuration
//     AUDIO_UNDERRUN_COUNT_EN  when defined, adds the 16-bit underrun_count
//                              output; otherwise the port and counter are absent.
// ---------------------------------------------------------------------------
module audio_pcm_feeder #(
  parameter int unsigned AUDIO_BITS  = 12,
  parameter int unsigned CLK_HZ      = 50000000,
  parameter int unsigned SAMPLE_HZ   = 44100,
  parameter int unsigned FIFO_AW     = 4,
  parameter int unsigned PRIME_LEVEL = 8
) (
  input  logic                  clk,
  input  logic                  aclr_,
  audio_pcm_feeder_if.slave     pcm_in,
  output logic [AUDIO_BITS-1:0] left_pcm,
  output logic [AUDIO_BITS-1:0] right_pcm,
  output logic                  sample_strobe,
  output logic                  underrun,
  output logic                  playing,
  output logic [FIFO_AW:0]      fill_level
`ifdef AUDIO_UNDERRUN_COUNT_EN
  ,
  output logic [15:0]           underrun_count
`endif
);

  localparam int unsigned Depth  = 2 ** FIFO_AW;
  localparam int unsigned AccW   = $clog2(CLK_HZ + SAMPLE_HZ);
  localparam int unsigned EntryW = 2 * AUDIO_BITS;

  localparam logic [AccW-1:0]    ClkHz      = AccW'(CLK_HZ);
  localparam logic [AccW-1:0]    SampleHz   = AccW'(SAMPLE_HZ);
  localparam logic [FIFO_AW:0]   FullLevel  = (FIFO_AW + 1)'(Depth);
  localparam logic [FIFO_AW:0]   PrimeLevel = (FIFO_AW + 1)'(PRIME_LEVEL);

  typedef enum logic [0:0] {
    StPrime,
    StPlay
  } state_e;

  // ---------------------------------------------------------------------------
  // Phase accumulator. acc stays below CLK_HZ, so acc + SAMPLE_HZ never exceeds
  // CLK_HZ + SAMPLE_HZ - 1 and fits in AccW bits without a carry.
  // ---------------------------------------------------------------------------
  logic [AccW-1:0] acc_q, acc_d, acc_sum;
  logic            tick;

  always_comb begin
    acc_sum = acc_q + SampleHz;
    tick    = (acc_sum >= ClkHz);
    acc_d   = tick ? (acc_sum - ClkHz) : acc_sum;
  end

  always_ff @(posedge clk or negedge aclr_) begin
    if (!aclr_) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  state_e state_q, state_d;
  logic   play_en;
  logic   full, empty;
  logic   push, pop, underrun_evt;
  logic [FIFO_AW:0] fill_q, fill_d;

  always_ff @(posedge clk or negedge aclr_) begin
    if (!aclr_) begin
      state_q <= StPrime;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StPrime: begin
        // Uses the registered level, so a tick in the transition cycle cannot pop.
        if (fill_q >= PrimeLevel) begin
          state_d = StPlay;
        end
      end
      StPlay: begin
        if (underrun_evt) begin
          state_d = StPrime;
        end
      end
      default: state_d = StPrime;
    endcase
  end

  always_comb begin
    play_en = (state_q == StPlay);
    playing = play_en;
  end

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [EntryW-1:0]  mem_q [Depth];

  always_comb begin
    full         = (fill_q == FullLevel);
    empty        = (fill_q == '0);
    // in_ready depends only on registered state, never on in_valid.
    push         = pcm_in.in_valid && !full;
    pop          = tick && play_en && !empty;
    underrun_evt = tick && play_en && empty;

    fill_d = fill_q;
    unique case ({push, pop})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase
  end

  assign pcm_in.in_ready = !full;
  assign fill_level      = fill_q;

  always_ff @(posedge clk or negedge aclr_) begin
    if (!aclr_) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      fill_q <= fill_d;
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {pcm_in.in_left, pcm_in.in_right};
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  logic [AUDIO_BITS-1:0] left_q, right_q;
  logic                  strobe_q, underrun_q;

  always_ff @(posedge clk or negedge aclr_) begin
    if (!aclr_) begin
      left_q     <= '0;
      right_q    <= '0;
      strobe_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      if (pop) begin
        {left_q, right_q} <= mem_q[rd_ptr_q];
      end
      strobe_q   <= pop;
      underrun_q <= underrun_evt;
    end
  end

  assign left_pcm      = left_q;
  assign right_pcm     = right_q;
  assign sample_strobe = strobe_q;
  assign underrun      = underrun_q;

`ifdef AUDIO_UNDERRUN_COUNT_EN
  logic [15:0] urun_cnt_q;

  always_ff @(posedge clk or negedge aclr_) begin
    if (!aclr_) begin
      urun_cnt_q <= '0;
    end else if (underrun_evt && (urun_cnt_q != 16'hFFFF)) begin
      urun_cnt_q <= urun_cnt_q + 16'd1;
    end
  end

  assign underrun_count = urun_cnt_q;
`endif

endmodule

// File: tb/tb_audio_pcm_feeder.sv
// Directed bench for audio_pcm_feeder with CLK_HZ=10, SAMPLE_HZ=3, FIFO_AW=2,
// PRIME_LEVEL=2. After each reset release, accumulator ticks land on edges
// 4,7,10,14,17,20,24,27,30,34,37,40,... ; the steps below are placed on those
// edge numbers (cyc counts rising edges since release).
module tb_audio_pcm_feeder;

  localparam int unsigned AB = 12;

  logic          clk   = 1'b0;
  logic          aclr_ = 1'b1;
  logic [AB-1:0] left_pcm, right_pcm;
  logic          sample_strobe, underrun, playing;
  logic [2:0]    fill_level;
`ifdef AUDIO_UNDERRUN_COUNT_EN
  logic [15:0]   underrun_count;
`endif

  int unsigned   cyc;
  logic [23:0]   sb [$];
  logic [23:0]   mon_exp;
  int            n_checks = 0;
  int            n_pass   = 0;

  audio_pcm_feeder_if #(.AUDIO_BITS(AB)) pcm_bus ();

  audio_pcm_feeder #(
    .AUDIO_BITS  (AB),
    .CLK_HZ      (10),
    .SAMPLE_HZ   (3),
    .FIFO_AW     (2),
    .PRIME_LEVEL (2)
  ) dut (
    .clk           (clk),
    .aclr_         (aclr_),
    .pcm_in        (pcm_bus),
    .left_pcm      (left_pcm),
    .right_pcm     (right_pcm),
    .sample_strobe (sample_strobe),
    .underrun      (underrun),
    .playing       (playing),
    .fill_level    (fill_level)
`ifdef AUDIO_UNDERRUN_COUNT_EN
    ,
    .underrun_count(underrun_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge aclr_) begin
    if (!aclr_) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Scoreboard: every strobe must present the oldest expected pair.
  always @(posedge clk) begin
    #1;
    if (aclr_ && sample_strobe) begin
      chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_exp = sb.pop_front();
        chk("pcm_pair", {8'd0, left_pcm, right_pcm}, {8'd0, mon_exp});
      end
    end
  end

  // Advance to 1 time unit after edge k (bounded).
  task automatic goto(input int unsigned k);
    int guard = 0;
    while (cyc < k && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (cyc != k) chk("goto_edge", cyc, k);
  endtask

  task automatic do_reset();
    aclr_            = 1'b0;
    pcm_bus.in_valid = 1'b0;
    sb.delete();
    #1;
    chk("rst_left",     left_pcm, 0);
    chk("rst_right",    right_pcm, 0);
    chk("rst_strobe",   sample_strobe, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_playing",  playing, 0);
    chk("rst_fill",     fill_level, 0);
    chk("rst_in_ready", pcm_bus.in_ready, 1);
`ifdef AUDIO_UNDERRUN_COUNT_EN
    chk("rst_urun_cnt", underrun_count, 0);
`endif
    @(posedge clk);
    #1;
    aclr_ = 1'b1;
    chk("held_after_release",
        {playing, sample_strobe, underrun, left_pcm, right_pcm, fill_level}, 0);
  endtask

  task automatic idle_run();
    for (int k = 1; k <= 22; k++) begin
      goto(k);
      chk("idle", {playing, sample_strobe, underrun, left_pcm, right_pcm}, 0);
    end
  endtask

  initial begin
    pcm_bus.in_valid = 1'b0;
    pcm_bus.in_left  = '0;
    pcm_bus.in_right = '0;
    #3;

    // Reset release with no pushes: nothing may come out.
    do_reset();
    idle_run();

    // Two pushes prime the FIFO, then two pops and an underrun.
    do_reset();
    pcm_bus.in_valid = 1'b1;
    pcm_bus.in_left  = 12'h111;
    pcm_bus.in_right = 12'h222;
    sb.push_back(24'h111222);
    goto(1);
    chk("fill_after_push1", fill_level, 1);
    pcm_bus.in_left  = 12'h333;
    pcm_bus.in_right = 12'h444;
    sb.push_back(24'h333444);
    goto(2);
    pcm_bus.in_valid = 1'b0;
    chk("fill_after_push2", fill_level, 2);
    chk("prime_still", playing, 0);
    goto(3);
    chk("playing_on", playing, 1);
    chk("no_pop_yet", sample_strobe, 0);
    goto(4);
    chk("strobe_1st", sample_strobe, 1);
    chk("left_1st", left_pcm, 12'h111);
    chk("right_1st", right_pcm, 12'h222);
    chk("fill_after_pop1", fill_level, 1);
    goto(5);
    chk("strobe_one_cycle", sample_strobe, 0);
    chk("left_hold", left_pcm, 12'h111);
    goto(7);
    chk("strobe_2nd", sample_strobe, 1);
    chk("pair_2nd", {left_pcm, right_pcm}, 24'h333444);
    chk("fill_empty", fill_level, 0);
    goto(10);
    chk("underrun_pulse", underrun, 1);
    chk("underrun_playing", playing, 0);
    chk("underrun_hold", {left_pcm, right_pcm}, 24'h333444);
    chk("underrun_no_strobe", sample_strobe, 0);
`ifdef AUDIO_UNDERRUN_COUNT_EN
    chk("urun_cnt_1", underrun_count, 1);
`endif
    goto(11);
    chk("underrun_one_cycle", underrun, 0);
    chk("hold_after_underrun", {left_pcm, right_pcm}, 24'h333444);

    // Hold in_valid across five cycles: four accepted, fifth refused.
    for (int i = 0; i < 5; i++) begin
      pcm_bus.in_valid = 1'b1;
      pcm_bus.in_left  = 12'h500 + AB'(i);
      pcm_bus.in_right = 12'h600 + AB'(i);
      chk("in_ready_pre", pcm_bus.in_ready, 32'(i < 4));
      if (i < 4) sb.push_back({12'h500 + AB'(i), 12'h600 + AB'(i)});
      goto(12 + i);
    end
    pcm_bus.in_valid = 1'b0;
    chk("fill_full", fill_level, 4);
    chk("full_not_ready", pcm_bus.in_ready, 0);
    chk("full_playing", playing, 1);
    goto(17);
    chk("pop_from_full", sample_strobe, 1);
    chk("fill_3", fill_level, 3);

    // Push coinciding with a popping tick at fill_level 3.
    goto(19);
    pcm_bus.in_valid = 1'b1;
    pcm_bus.in_left  = 12'h5F5;
    pcm_bus.in_right = 12'h6F5;
    sb.push_back(24'h5F56F5);
    goto(20);
    pcm_bus.in_valid = 1'b0;
    chk("push_pop_fill", fill_level, 3);
    chk("push_pop_strobe", sample_strobe, 1);

    // Drain to the second underrun.
    goto(34);
    chk("underrun2_pulse", underrun, 1);
    chk("underrun2_playing", playing, 0);
    chk("underrun2_hold", {left_pcm, right_pcm}, 24'h5F56F5);
`ifdef AUDIO_UNDERRUN_COUNT_EN
    chk("urun_cnt_2", underrun_count, 2);
`endif
    goto(35);
    chk("underrun2_one_cycle", underrun, 0);
    chk("sb_drained", sb.size(), 0);

    // Refill to 3 (not to be output), then reset mid-stream.
    pcm_bus.in_valid = 1'b1;
    pcm_bus.in_left  = 12'h7A0;
    pcm_bus.in_right = 12'h7B0;
    goto(38);
    pcm_bus.in_valid = 1'b0;
    chk("pre_reset_fill", fill_level, 3);
    chk("pre_reset_playing", playing, 1);
    do_reset();
    idle_run();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
